receiver: RTL

RECEIVER -- requirements
Module: receiver

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rx_shift_buffer.sv | 34 +++
 rtl/receiver.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: the frame FSM state encoding (same state names as
// the transmitter FSM) and the default frame format.
// -----------------------------------------------------------------------------
package uart_pkg;

    // ST_ prefix keeps the state names clear of the PARITY module parameter.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    localparam int   DEFAULT_DATA_BITS = 8;
    localparam logic DEFAULT_PARITY    = 1'b1;   // 0 = even, 1 = odd

endpackage

// File: rtl/rx_shift_buffer.sv
// -----------------------------------------------------------------------------
// rx_shift_buffer
// Four-entry history of received bytes. Entry 0 is the newest. On i_shift_en
// every entry moves one place older, i_data enters at entry 0 and the oldest
// entry is discarded.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low clear (all entries to 8'h00)
//   i_shift_en in   push i_data into the history this cycle
//   i_data     in   byte to push
//   o_buf      out  history, o_buf[0] newest .. o_buf[3] oldest
// -----------------------------------------------------------------------------
module rx_shift_buffer (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_shift_en,
    input  logic [7:0]      i_data,
    output logic [3:0][7:0] o_buf
);

    logic [3:0][7:0] r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (i_shift_en) begin
            r_buf <= {r_buf[2:0], i_data};
        end
    end

    assign o_buf = r_buf;

endmodule

// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver
// UART receiver: start bit, DATA_BITS data bits (LSB first), one parity bit,
// one stop bit. Good frames are pushed into a 4-deep byte history. Each frame
// ends in exactly one of rx_valid / parity_err / frame_err, one cycle after
// the stop-bit mid-sample. A low stop bit parks the FSM in BREAK until the line
// returns high.
//
// Ports
//   clk                  in   system clock
//   rst_n                in   asynchronous active-low reset
//   RX                   in   asynchronous serial line, idle high
//   rx_valid             out  1-cycle pulse, good frame stored in RXBUF
//   parity_err           out  1-cycle pulse, frame dropped for bad parity
//   frame_err            out  1-cycle pulse, frame dropped for low stop bit
//   busy                 out  FSM not in IDLE
//   most_recent_received out  RXBUF[0]
//   RXBUF                out  byte history, [0] newest .. [3] oldest
// -----------------------------------------------------------------------------
module receiver
    import uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = 16,
    parameter int   DATA_BITS    = DEFAULT_DATA_BITS,
    parameter logic PARITY       = DEFAULT_PARITY
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RX,
    output logic            rx_valid,
    output logic            parity_err,
    output logic            frame_err,
    output logic            busy,
    output logic [7:0]      most_recent_received,
    output logic [3:0][7:0] RXBUF
);

    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int BW    = $clog2(DATA_BITS) + 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    // Synchronizer and edge detect
    logic r_sync1;
    logic r_rx_s;
    logic r_rx_prev;

    // FSM and datapath
    uart_state_t          r_state,  w_state_next;
    logic [TW-1:0]        r_timer,  w_timer_next;
    logic [BW-1:0]        r_bit_idx, w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift,  w_shift_next;
    logic                 r_par_ok, w_par_ok_next;
    logic                 r_rx_valid,   w_rx_valid_next;
    logic                 r_parity_err, w_parity_err_next;
    logic                 r_frame_err,  w_frame_err_next;
    logic                 w_shift_en;
    logic                 w_fall;
    logic [IDX_W-1:0]     w_bit_sel;
    logic [7:0]           w_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= RX;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall    = r_rx_prev & ~r_rx_s;
    assign w_bit_sel = r_bit_idx[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_ok     <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_bit_idx    <= w_bit_idx_next;
            r_shift      <= w_shift_next;
            r_par_ok     <= w_par_ok_next;
            r_rx_valid   <= w_rx_valid_next;
            r_parity_err <= w_parity_err_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    // The timer counts freely and is cleared at every sample point, so the
    // first sample lands at half a bit after the edge and every later one a
    // full bit after that.
    always_comb begin
        w_state_next      = r_state;
        w_timer_next      = r_timer + 1'b1;
        w_bit_idx_next    = r_bit_idx;
        w_shift_next      = r_shift;
        w_par_ok_next     = r_par_ok;
        w_rx_valid_next   = 1'b0;
        w_parity_err_next = 1'b0;
        w_frame_err_next  = 1'b0;
        w_shift_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_timer_next = '0;
                if (w_fall) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_timer == HALF_M1) begin
                    w_timer_next = '0;
                    if (!r_rx_s) begin
                        w_state_next   = ST_DATA;
                        w_bit_idx_next = '0;
                    end else begin
                        w_state_next = ST_IDLE;   // glitch, not a start bit
                    end
                end
            end
            ST_DATA: begin
                if (r_timer == FULL_M1) begin
                    w_timer_next            = '0;
                    w_shift_next[w_bit_sel] = r_rx_s;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = ST_PARITY;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (r_timer == FULL_M1) begin
                    w_timer_next  = '0;
                    w_par_ok_next = ((^r_shift ^ r_rx_s) == PARITY);
                    w_state_next  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_timer == FULL_M1) begin
                    w_timer_next = '0;
                    if (r_rx_s) begin
                        w_state_next = ST_IDLE;
                        if (r_par_ok) begin
                            w_rx_valid_next = 1'b1;
                            w_shift_en      = 1'b1;
                        end else begin
                            w_parity_err_next = 1'b1;
                        end
                    end else begin
                        // Framing error takes priority over any parity result.
                        w_frame_err_next = 1'b1;
                        w_state_next     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_timer_next = '0;
                if (r_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    // Map the DATA_BITS-wide frame onto the 8-bit history, zero padding
    // narrow frames.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            if (gi < DATA_BITS) begin : g_bit
                assign w_byte[gi] = r_shift[gi];
            end else begin : g_pad
                assign w_byte[gi] = 1'b0;
            end
        end
    endgenerate

    // Enable comes from the stop-sample cycle, so RXBUF changes on the same
    // edge that raises rx_valid.
    rx_shift_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_shift_en (w_shift_en),
        .i_data     (w_byte),
        .o_buf      (RXBUF)
    );

    assign rx_valid             = r_rx_valid;
    assign parity_err           = r_parity_err;
    assign frame_err            = r_frame_err;
    assign busy                 = (r_state != ST_IDLE);
    assign most_recent_received = RXBUF[0];

endmodule
